// File: rtl/neural_soc_input_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : neural_soc_input_pio_if
// Brief    : Avalon-MM register bus for the input PIO.
// Revision : 1.0
// ============================================================================
interface neural_soc_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/neural_soc_input_pio.sv
`default_nettype none
// ============================================================================
// Module   : neural_soc_input_pio
// Brief    : Synchronised, debounced switch inputs with edge capture and IRQ.
// Revision : 1.0
// ============================================================================
module neural_soc_input_pio #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    neural_soc_input_pio_if.slave   bus,
    input  wire logic [WIDTH-1:0]   in_port,
    output logic                    irq
);

    localparam int             c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdmux;
    logic             w_wr;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // A bit only commits once it has disagreed with stable for DEBOUNCE_CYCLES
    // consecutive edges; any agreement restarts the count.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [c_CW-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_s[b] == r_stable[b]) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end

        assign w_load[b] = (w_s[b] != r_stable[b]) && (r_cnt == c_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
        end else begin
            r_stable <= (r_stable & ~w_load) | (w_s & w_load);
        end
    end

    always_comb begin
        w_evt = '0;
        case (EDGE_TYPE)
            0:       w_evt = w_load & w_s;
            1:       w_evt = w_load & ~w_s;
            default: w_evt = w_load;
        endcase
    end

    assign w_wr  = bus.chipselect && !bus.write_n;
    assign w_clr = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && bus.address == 2'd2) begin
            r_irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // New events are OR-ed in after the clear so a coincident event survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_evt;
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (bus.address)
            2'd0:    w_rdmux = 32'(r_stable);
            2'd2:    w_rdmux = 32'(r_irqmask);
            2'd3:    w_rdmux = 32'(r_edgecap);
            default: w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= w_rdmux;
        end
    end

    assign irq      = |(r_edgecap & r_irqmask);
    assign w_unused = ^bus.writedata;

endmodule
`default_nettype wire

// File: doc/neural_soc_input_pio.md
NEURAL_SOC_INPUT_PIO -- requirements
Module: neural_soc_input_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input bits (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per bit (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive cycles a change must persist (1..65535; 1 = no filtering).
REQ-004 SHALL have parameter EDGE_TYPE, default 0, capture on 0 rising, 1 falling, 2 any edge.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port address, input, 2, Avalon-MM register select.
REQ-008 SHALL have port chipselect, input, 1, slave select.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port in_port, input, WIDTH, asynchronous external inputs (switches).
REQ-013 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-014 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain; chain output = sync bit s.
REQ-015 SHALL hold per bit a stable value and a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-016 SHALL, on an edge where s != stable and counter == DEBOUNCE_CYCLES-1, load stable <= s and counter <= 0.
REQ-017 SHALL, on an edge where s != stable and counter < DEBOUNCE_CYCLES-1, increment counter.
REQ-018 SHALL, on an edge where s == stable, clear counter (glitch rejection; no wrap-around possible).
REQ-019 SHALL make a change held at in_port before edge 1 appear in stable after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-020 SHALL set edgecapture bit on the same edge stable changes in the EDGE_TYPE direction.
REQ-021 SHALL map registers: addr 0 data (stable, zero-extended, read-only); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (WIDTH bits, R/W); addr 3 edgecapture (read; write-1-to-clear).
REQ-022 SHALL perform writes when chipselect=1 and write_n=0; writedata bits above WIDTH ignored.
REQ-023 SHALL update readdata every edge from address (read latency 1, no wait states); bits 31:WIDTH read 0.
REQ-024 SHALL, on the same edge a write-1-to-clear and a new edge event hit one edgecapture bit, leave it set (set wins).
REQ-025 SHALL drive irq = |(edgecapture & irqmask), derived only from registers (glitch-free).
REQ-026 SHALL not change any register on a write with chipselect=0.

Reset
REQ-027 SHALL, while reset=1 at an edge, clear sync chains, stable, counters, irqmask, edgecapture and readdata to 0; irq=0 following that edge.
REQ-028 SHALL treat an input already high at reset release as a rising change: stable updates and edge captured after SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-029 SHALL abort any in-progress debounce count on reset, with no edge captured from pre-reset history.

Verification (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0)
REQ-030 SHALL cover: in_port 0x00->0x05 held -> data read 0x05 after edge 6, not before; edgecapture=0x05.
REQ-031 SHALL cover: bit0 pulse high for 3 cycles -> stable, data and edgecapture remain 0x00.
REQ-032 SHALL cover: irqmask=0x04, edgecapture=0x05 -> irq=1; write 0x04 to addr 3 -> edgecapture 0x01, irq 0.
REQ-033 SHALL cover: clear write of 0x01 on the same edge bit0 captures a new rising edge -> edgecapture bit0 stays 1.
REQ-034 SHALL cover: falling 0x05->0x00 with EDGE_TYPE=0 -> no capture; with EDGE_TYPE=2 -> edgecapture 0x05.
REQ-035 SHALL cover: reset asserted mid-count (counter=2) -> all registers 0 after the reset edge; read addr 1 and upper data bits return 0.
